pipe_ctrl: RTL

//  Pipeline control for the 5-stage RV32I core. Drives the ENA inputs of the IF/ID, ID/EX, EX/MEM, MEM/WB
//  and PC registers, which are built from non-reset registers, so it owns the reset-cleared valid bits.

---
 rtl/riscv_pkg.sv | 5 +
 rtl/hazard_lu.sv | 15 +
 rtl/pipe_ctrl.sv | 79 +++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and defaults for the RV32I core control logic
package riscv_pkg;
   localparam int REG_ADDR_DEF = 5;
   typedef enum logic {RUN, FREEZE} pctl_state_t;
endpackage

// File: rtl/hazard_lu.sv
// hazard_lu: load-use register match between the ID and EX instructions
module hazard_lu import riscv_pkg::*; #(
   parameter int REG_ADDR = REG_ADDR_DEF
) (
   input  logic [REG_ADDR-1:0] rs1,
   input  logic [REG_ADDR-1:0] rs2,
   input  logic [REG_ADDR-1:0] rd,
   input  logic                use1,
   input  logic                use2,
   input  logic                load,
   output logic                hit
);
   // x0 is hardwired, so a load into it never creates a dependency
   assign hit = load && rd != '0 && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline enables, valid bits, memory freeze FSM and stall/flush counters
module pipe_ctrl import riscv_pkg::*; #(
   parameter int REG_ADDR = REG_ADDR_DEF,
   parameter int CNT_W    = 16,
   parameter int TIMEOUT  = 255
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic [REG_ADDR-1:0] ID_RS1,
   input  logic [REG_ADDR-1:0] ID_RS2,
   input  logic                ID_USE1,
   input  logic                ID_USE2,
   input  logic [REG_ADDR-1:0] EX_RD,
   input  logic                EX_LOAD,
   input  logic                BR_TAKEN,
   input  logic                IMEM_RDY,
   input  logic                DMEM_REQ,
   input  logic                DMEM_ACK,
   output logic                PC_ENA,
   output logic                PC_SEL,
   output logic                IFID_ENA,
   output logic                IDEX_ENA,
   output logic                EXMEM_ENA,
   output logic                MEMWB_ENA,
   output logic                V_ID,
   output logic                V_EX,
   output logic                V_MEM,
   output logic                V_WB,
   output logic                MEM_ERR,
   output logic [CNT_W-1:0]    STALL_CNT,
   output logic [CNT_W-1:0]    FLUSH_CNT
);
   localparam int TW = $clog2(TIMEOUT + 1);
   pctl_state_t   state;
   logic [TW-1:0] timer;
   logic          lu_hit, frz, flush, lu, fb;
   hazard_lu #(.REG_ADDR(REG_ADDR)) u_lu (
      .rs1(ID_RS1), .rs2(ID_RS2), .rd(EX_RD),
      .use1(ID_USE1), .use2(ID_USE2), .load(EX_LOAD), .hit(lu_hit)
   );
   // Mutually exclusive cases, highest priority first
   always_comb begin
      frz       = V_MEM && DMEM_REQ && !DMEM_ACK;
      flush     = !frz && V_EX && BR_TAKEN;
      lu        = !frz && !flush && V_ID && V_EX && lu_hit;
      fb        = !frz && !flush && !lu && !IMEM_RDY;
      PC_ENA    = !frz && !lu && !fb;
      PC_SEL    = flush;
      IFID_ENA  = !frz && !lu;
      IDEX_ENA  = !frz;
      EXMEM_ENA = !frz;
      MEMWB_ENA = !frz;
   end
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= RUN;
         timer     <= '0;
         MEM_ERR   <= 1'b0;
         V_ID      <= 1'b0;
         V_EX      <= 1'b0;
         V_MEM     <= 1'b0;
         V_WB      <= 1'b0;
         STALL_CNT <= '0;
         FLUSH_CNT <= '0;
      end else begin
         state   <= frz ? FREEZE : RUN;
         timer   <= !frz ? '0 : state == RUN ? TW'(1) : timer == TW'(TIMEOUT) ? timer : timer + 1'b1;
         MEM_ERR <= MEM_ERR || (frz && timer == TW'(TIMEOUT - 1));
         if (!frz) begin
            V_ID  <= lu ? V_ID : !(flush || fb);
            V_EX  <= !(flush || lu) && V_ID;
            V_MEM <= V_EX;
            V_WB  <= V_MEM;
         end
         if ((lu || fb) && STALL_CNT != '1) STALL_CNT <= STALL_CNT + 1'b1;
         if (flush && FLUSH_CNT != '1) FLUSH_CNT <= FLUSH_CNT + 1'b1;
      end
   end
endmodule
